// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader and its output FIFO.
package ram_stream_reader_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Output buffer depth; two entries are enough to cover the one-cycle RAM
  // latency while still streaming one beat per cycle.
  localparam int FIFO_DEPTH = 2;

  // Word width carried by a buffer entry (matches the RAM word width).
  localparam int ENTRY_DATA_W = 16;

  // One buffered stream beat.
  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic                    last;
  } entry_t;

endpackage

// File: rtl/ram_stream_reader_skid_fifo.sv
// Two-entry FIFO holding read results until the consumer accepts them.
// Supports push and pop in the same cycle; exposes its fill count.
module ram_stream_skid_fifo
  import ram_stream_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  entry_t     push_entry_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // Qualify push/pop against the current fill level and compute next pointers.
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q < 2'(FIFO_DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Control state: pointers and fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side initiator for a single-port block RAM: sweeps a contiguous
// (wrapping) address range and presents the words as a valid/ready stream
// with a last flag. Issue is throttled by a credit check so the two-entry
// output FIFO can never overflow, yet one beat per cycle flows when the
// consumer is always ready.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = ENTRY_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              issue;
  logic              pop;
  logic              credit_ok;
  logic [2:0]        occupancy;
  logic [2:0]        credit_limit;
  logic [1:0]        fifo_count;
  entry_t            push_entry;
  entry_t            head;

  // Credit check: entries held plus the read still in flight, less the beat
  // leaving this cycle, must stay below the FIFO depth.
  always_comb begin
    pop          = m_valid && m_ready;
    occupancy    = {1'b0, fifo_count} + {2'b00, inflight_q};
    credit_limit = 3'(FIFO_DEPTH) + {2'b00, pop};
    credit_ok    = occupancy < credit_limit;
    issue        = (state_q == RUN) && (rem_q != '0) && credit_ok;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A zero-length command spends one cycle in RUN with
  // nothing to issue and then finishes, so no RAM access or beat occurs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (rem_q == '0) begin
          state_d = FINISH;
        end else if (issue && (rem_q == (ADDR_W+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == FINISH);
    ram_en = issue;
  end

  // Address pointer and remaining count: load on accepted start, step per read.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if ((state_q == IDLE) && start) begin
      addr_d = base_addr;
      rem_d  = len;
    end else if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W+1)'(1);
    end
  end

  // Transfer counters and the one-deep record of the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == (ADDR_W+1)'(1));
    end
  end

  assign ram_addr = addr_q;

  // RAM data lands the cycle after ram_en and is captured into the FIFO then.
  assign push_entry.data = ram_dout;
  assign push_entry.last = inflight_last_q;

  ram_stream_skid_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = m_valid ? head.data : '0;
  assign m_last  = m_valid ? head.last : 1'b0;

endmodule
